// File: rtl/core_ex_mdu_pkg.sv
// Shared op/state encodings and operand-interpretation helpers for the
// EX-stage multiply/divide unit.
package core_ex_mdu_pkg;

  localparam int unsigned MDU_OP_WIDTH = 3;

  typedef enum logic [MDU_OP_WIDTH-1:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

  function automatic logic op_is_div(input mdu_op_e op);
    return op inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU};
  endfunction

  function automatic logic op_rs1_signed(input mdu_op_e op);
    return op inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
  endfunction

  function automatic logic op_rs2_signed(input mdu_op_e op);
    return op inside {MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM};
  endfunction

endpackage

// File: rtl/core_ex_mdu_divstep.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the
// divisor, keep the difference only when it does not go negative.
module core_ex_mdu_divstep #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic            dividend_bit,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic            quo_bit
);

  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;

  always_comb begin
    shifted = {rem_in, dividend_bit};
    quo_bit = (shifted >= {1'b0, divisor});
    // rem_in < divisor, so a successful subtraction always fits in XLEN bits
    diff    = shifted[XLEN-1:0] - divisor;
    rem_out = quo_bit ? diff : shifted[XLEN-1:0];
  end

endmodule

// File: rtl/core_ex_mdu.sv
// Multi-cycle RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, sign fixup on the way out.
module core_ex_mdu
  import core_ex_mdu_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned FAST_MUL = 0,
  parameter int unsigned TAG_W    = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [MDU_OP_WIDTH-1:0] req_op,
  input  logic [XLEN-1:0]         req_rs1,
  input  logic [XLEN-1:0]         req_rs2,
  input  logic [TAG_W-1:0]        req_tag,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [XLEN-1:0]         rsp_result,
  output logic [TAG_W-1:0]        rsp_tag,
  output logic                    busy
);

  localparam int unsigned     CNT_W    = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0] SMIN     = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e state_q, state_d;
  mdu_op_e    op_q, new_op;

  logic [TAG_W-1:0]  tag_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              neg_q, neg_r_q;
  logic [XLEN-1:0]   mcand_q;
  logic [2*XLEN-1:0] prod_q;

  logic              accept;
  logic              rs1_neg, rs2_neg, is_div, div_zero, div_ovf, short_path;
  logic [XLEN-1:0]   rs1_mag, rs2_mag;
  logic [2*XLEN-1:0] fast_prod;

  logic [XLEN-1:0]   prod_hi, prod_lo, addend;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next, div_next, prod_neg, mul_fix;
  logic [XLEN-1:0]   div_rem, rem_neg, result;
  logic              div_q;

  assign new_op    = mdu_op_e'(req_op);
  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign accept    = req_valid & req_ready & ~flush;

  always_comb begin
    rs1_neg    = op_rs1_signed(new_op) & req_rs1[XLEN-1];
    rs2_neg    = op_rs2_signed(new_op) & req_rs2[XLEN-1];
    rs1_mag    = rs1_neg ? ('0 - req_rs1) : req_rs1;
    rs2_mag    = rs2_neg ? ('0 - req_rs2) : req_rs2;
    is_div     = op_is_div(new_op);
    div_zero   = (req_rs2 == '0);
    div_ovf    = (new_op inside {MDU_DIV, MDU_REM}) && (req_rs1 == SMIN) && (req_rs2 == '1);
    short_path = is_div ? (div_zero | div_ovf) : (FAST_MUL != 0);
    fast_prod  = {{XLEN{1'b0}}, rs1_mag} * {{XLEN{1'b0}}, rs2_mag};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = short_path ? ST_DONE : ST_CALC;
      ST_CALC: if (cnt_q == CNT_LAST) state_d = ST_DONE;
      ST_DONE: if (rsp_valid && rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  core_ex_mdu_divstep #(.XLEN(XLEN)) u_divstep (
    .rem_in       (prod_hi),
    .dividend_bit (prod_lo[XLEN-1]),
    .divisor      (mcand_q),
    .rem_out      (div_rem),
    .quo_bit      (div_q)
  );

  // prod_q doubles as {remainder, dividend->quotient} while dividing
  always_comb begin
    prod_hi  = prod_q[2*XLEN-1:XLEN];
    prod_lo  = prod_q[XLEN-1:0];
    addend   = prod_q[0] ? mcand_q : '0;
    mul_sum  = {1'b0, prod_hi} + {1'b0, addend};
    mul_next = {mul_sum, prod_lo[XLEN-1:1]};
    div_next = {div_rem, prod_lo[XLEN-2:0], div_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= MDU_MUL;
      tag_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      neg_r_q <= 1'b0;
      mcand_q <= '0;
      prod_q  <= '0;
    end else if (accept) begin
      op_q    <= new_op;
      tag_q   <= req_tag;
      cnt_q   <= '0;
      mcand_q <= is_div ? rs2_mag : rs1_mag;
      neg_q   <= rs1_neg ^ rs2_neg;
      neg_r_q <= rs1_neg;
      if (is_div) begin
        // special cases preload the final quotient/remainder with no fixup
        if (div_zero) begin
          prod_q  <= {req_rs1, {XLEN{1'b1}}};
          neg_q   <= 1'b0;
          neg_r_q <= 1'b0;
        end else if (div_ovf) begin
          prod_q  <= {{XLEN{1'b0}}, req_rs1};
          neg_q   <= 1'b0;
          neg_r_q <= 1'b0;
        end else begin
          prod_q <= {{XLEN{1'b0}}, rs1_mag};
        end
      end else if (FAST_MUL != 0) begin
        prod_q <= fast_prod;
      end else begin
        prod_q <= {{XLEN{1'b0}}, rs2_mag};
      end
    end else if (state_q == ST_CALC) begin
      cnt_q  <= cnt_q + 1'b1;
      prod_q <= op_is_div(op_q) ? div_next : mul_next;
    end
  end

  // low half of -prod equals -(low half), so it also serves the quotient
  always_comb begin
    prod_neg = '0 - prod_q;
    mul_fix  = neg_q ? prod_neg : prod_q;
    rem_neg  = '0 - prod_hi;
    case (op_q)
      MDU_MUL:                        result = mul_fix[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: result = mul_fix[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:              result = neg_q ? prod_neg[XLEN-1:0] : prod_lo;
      default:                        result = neg_r_q ? rem_neg : prod_hi;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_tag    <= '0;
    end else if (flush) begin
      rsp_valid <= 1'b0;
    end else if (state_q == ST_DONE) begin
      if (!rsp_valid) begin
        rsp_valid  <= 1'b1;
        rsp_result <= result;
        rsp_tag    <= tag_q;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule
